// File: rtl/inst_responder_way0_pkg.sv
// -----------------------------------------------------------------------------
// bnine_ifetch_defs
//
// Definitions shared by the way0 instruction-fetch responder and its store:
//   - ifetch_state_e   : responder FSM state encoding (IDLE / WAIT / RESP)
//   - ALIGN_FAULT_INST : word returned for a misaligned fetch
//   - cnt_width()      : width of the latency down-counter for a given LATENCY
// -----------------------------------------------------------------------------
package bnine_ifetch_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ifetch_state_e;

  localparam logic [31:0] ALIGN_FAULT_INST = 32'h0000_0000;

  // The counter is loaded with LATENCY-2 and counts down to zero, so it has to
  // hold values up to LATENCY-2. Keep at least one bit so the register exists
  // even for LATENCY 1 or 2, where it never leaves zero.
  function automatic int cnt_width(input int latency);
    if (latency > 2) begin
      return $clog2(latency - 1);
    end
    return 1;
  endfunction

endpackage

// File: rtl/inst_responder_way0_store.sv
// -----------------------------------------------------------------------------
// inst_store_way0
//
// DEPTH x 32 word-addressed instruction store with one synchronous write port
// and one registered read port. A write and a read to the same index on the
// same edge return the old word (read-before-write).
//
// The array itself is never reset. Only the read register is reset, because
// its value is visible on the responder's inst_fetch_o.
//
// Ports:
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset (read register only)
//   wr_en     in   write enable
//   wr_addr   in   word index to write
//   wr_data   in   word to write
//   rd_en     in   capture mem[rd_addr] into rd_data on this edge
//   rd_addr   in   word index to read
//   rd_data   out  registered read word; holds while rd_en is low
// -----------------------------------------------------------------------------
module inst_store_way0 #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Both blocks sample mem on the same edge, so a colliding read sees the
  // pre-write contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_responder_way0.sv
// -----------------------------------------------------------------------------
// inst_responder_way0
//
// Memory-side responder for the way0 instruction-fetch handshake. The block
// captures one fetch request, waits a fixed LATENCY, then presents one
// instruction word for a single cycle together with dataOk_o. Instructions
// come from an on-chip store, which can be loaded through a side port at any
// time.
//
// Parameters:
//   DEPTH    instruction words in the store (power of two, at most 2**30)
//   LATENCY  cycles from request capture to dataOk_o (at least 1)
//
// Ports:
//   clk               in   clock
//   reset_n           in   asynchronous active-low reset
//   request_i         in   fetch request, held with a stable address until dataOk_o
//   instAddr_fetch_i  in   byte address; bits [log2(DEPTH)+1:2] index the store
//   flush_i           in   cancels an in-flight access and gates dataOk_o
//   dataOk_o          out  one-cycle pulse; inst_fetch_o is valid in this cycle
//   inst_fetch_o      out  returned instruction; holds outside the response cycle
//   misalign_o        out  pulses with dataOk_o for a misaligned fetch
//   load_en_i         in   store write enable
//   load_addr_i       in   store word index to write
//   load_data_i       in   store word to write
//
// Optional feature, macro INST_ALIGN_CHECK_EN:
//   When defined, a fetch whose address has non-zero bits [1:0] completes at
//   the normal latency with inst_fetch_o = ALIGN_FAULT_INST and misalign_o = 1.
//   When undefined, address bits [1:0] are ignored and misalign_o is held at 0.
// -----------------------------------------------------------------------------
module inst_responder_way0
  import bnine_ifetch_defs::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     request_i,
  input  logic [31:0]              instAddr_fetch_i,
  input  logic                     flush_i,
  output logic                     dataOk_o,
  output logic [31:0]              inst_fetch_o,
  output logic                     misalign_o,
  input  logic                     load_en_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [31:0]              load_data_i
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CNT_W    = cnt_width(LATENCY);
  localparam int CNT_LOAD = (LATENCY > 1) ? (LATENCY - 2) : 0;

  ifetch_state_e    state_q;
  ifetch_state_e    state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             capture;

  logic [AW-1:0]    idx_p0;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [31:0]      rd_data_p1;
  logic             resp_ok;

  // Next-state and counter logic. The response cycle never looks at
  // request_i: the initiator only advances its address after seeing
  // dataOk_o, so a request seen in RESP would be the old one again.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (request_i && !flush_i) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(CNT_LOAD);
          end
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- p0: capture the word index of the accepted request ----
  // Upper address bits are dropped, so fetches wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (capture) begin
      idx_p0 <= instAddr_fetch_i[AW+1:2];
    end
  end

  // ---- p1: store read, registered on the edge that enters RESP ----
  // With LATENCY 1 that edge is the capture edge itself, so the index is
  // taken straight from the address bus instead of from idx_p0.
  assign rd_en   = (state_d == RESP) && (state_q != RESP);
  assign rd_addr = (state_q == IDLE) ? instAddr_fetch_i[AW+1:2] : idx_p0;

  inst_store_way0 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (load_en_i),
    .wr_addr (load_addr_i),
    .wr_data (load_data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data_p1)
  );

  // ---- response: state-driven pulse, gated combinationally by flush ----
  assign resp_ok  = (state_q == RESP) && !flush_i;
  assign dataOk_o = resp_ok;

`ifdef INST_ALIGN_CHECK_EN
  logic mis_p0;
  logic unused_addr_bits;

  // The misalign flag is kept until the next capture so that inst_fetch_o
  // keeps showing the fault word after the response, like any other word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mis_p0 <= 1'b0;
    end else if (capture) begin
      mis_p0 <= |instAddr_fetch_i[1:0];
    end
  end

  assign inst_fetch_o     = mis_p0 ? ALIGN_FAULT_INST : rd_data_p1;
  assign misalign_o       = resp_ok && mis_p0;
  assign unused_addr_bits = ^instAddr_fetch_i[31:AW+2];
`else
  logic unused_addr_bits;

  assign inst_fetch_o     = rd_data_p1;
  assign misalign_o       = 1'b0;
  assign unused_addr_bits = ^{instAddr_fetch_i[31:AW+2], instAddr_fetch_i[1:0]};
`endif

endmodule

// File: tb/tb_inst_responder_way0.sv
// -----------------------------------------------------------------------------
// tb_inst_responder_way0
//
// Three responder instances with LATENCY 1, 2 and 3 share the clock, reset and
// the store load bus, so every store holds the same contents. Each has its own
// request, address and flush. Expected responses go into a scoreboard queue
// when a request is driven and are popped by a monitor whenever an instance
// raises dataOk_o.
// -----------------------------------------------------------------------------
module tb_inst_responder_way0;

  typedef struct packed {
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_a   [1:3];
  logic [31:0] addr_a  [1:3];
  logic        flush_a [1:3];
  logic        ok_a    [1:3];
  logic [31:0] inst_a  [1:3];
  logic        mis_a   [1:3];
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic [31:0] model [0:1023];
  exp_t        exp_q [$];
  int          nchecks = 0;
  int          nerrors = 0;

  always #5 clk = ~clk;

  inst_responder_way0 #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .request_i(req_a[1]), .instAddr_fetch_i(addr_a[1]),
    .flush_i(flush_a[1]), .dataOk_o(ok_a[1]), .inst_fetch_o(inst_a[1]), .misalign_o(mis_a[1]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data));

  inst_responder_way0 #(.DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .request_i(req_a[2]), .instAddr_fetch_i(addr_a[2]),
    .flush_i(flush_a[2]), .dataOk_o(ok_a[2]), .inst_fetch_o(inst_a[2]), .misalign_o(mis_a[2]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data));

  inst_responder_way0 #(.DEPTH(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .request_i(req_a[3]), .instAddr_fetch_i(addr_a[3]),
    .flush_i(flush_a[3]), .dataOk_o(ok_a[3]), .inst_fetch_o(inst_a[3]), .misalign_o(mis_a[3]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data));

  // Scoreboard monitor: sampled a little after the falling edge, once the
  // stimulus driven at that edge (including flush) has settled.
  always @(negedge clk) begin
    exp_t e;
    #2;
    for (int d = 1; d <= 3; d++) begin
      if (ok_a[d] === 1'b1) begin
        nchecks++;
        if (exp_q.size() == 0) begin
          nerrors++;
          $display("FAIL sb_unexpected dut_l%0d: got response inst=%h, required no response", d, inst_a[d]);
        end else begin
          e = exp_q.pop_front();
          if (inst_a[d] !== e.inst || mis_a[d] !== e.mis) begin
            nerrors++;
            $display("FAIL sb_resp dut_l%0d: got inst=%h mis=%b, required inst=%h mis=%b",
                     d, inst_a[d], mis_a[d], e.inst, e.mis);
          end
        end
      end
    end
  end

  function automatic exp_t expect_for(input logic [31:0] a);
    exp_t e;
    e.inst = model[a[11:2]];
    e.mis  = 1'b0;
`ifdef INST_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) begin
      e.inst = 32'h0000_0000;
      e.mis  = 1'b1;
    end
`endif
    return e;
  endfunction

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic load_word(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = idx[9:0];
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
    model[idx] = d;
  endtask

  task automatic issue(input int d, input logic [31:0] a);
    req_a[d]  = 1'b1;
    addr_a[d] = a;
    exp_q.push_back(expect_for(a));
  endtask

  // Counts falling edges until dataOk_o is seen or the budget runs out.
  task automatic wait_ok(input int d, input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ok_a[d] !== 1'b1 && cyc < max);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 1; d <= 3; d++) begin
      nchecks++;
      if (ok_a[d] !== 1'b0 || inst_a[d] !== 32'h0 || mis_a[d] !== 1'b0) begin
        nerrors++;
        $display("FAIL reset_outputs dut_l%0d: got ok=%b inst=%h mis=%b, required 0/00000000/0",
                 d, ok_a[d], inst_a[d], mis_a[d]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    int cyc;
    load_word(4, 32'h0010_0093);
    issue(2, 32'h10);
    wait_ok(2, 8, cyc);
    req_a[2] = 1'b0;
    nchecks++;
    if (ok_a[2] !== 1'b1 || cyc != 2) begin
      nerrors++;
      $display("FAIL single_latency: got ok=%b after %0d cycles, required ok=1 after 2", ok_a[2], cyc);
    end
    nchecks++;
    if (inst_a[2] !== 32'h0010_0093) begin
      nerrors++;
      $display("FAIL single_inst: got %h, required 00100093", inst_a[2]);
    end
    @(negedge clk);
    nchecks++;
    if (ok_a[2] !== 1'b0 || inst_a[2] !== 32'h0010_0093) begin
      nerrors++;
      $display("FAIL single_pulse_hold: got ok=%b inst=%h, required ok=0 inst=00100093", ok_a[2], inst_a[2]);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      wait_ok(1, 6, cyc);
      nchecks++;
      if (ok_a[1] !== 1'b1 || cyc != ((k == 0) ? 1 : 2)) begin
        nerrors++;
        $display("FAIL b2b_spacing[%0d]: got ok=%b after %0d cycles, required ok=1 after %0d",
                 k, ok_a[1], cyc, (k == 0) ? 1 : 2);
      end
      nchecks++;
      if (inst_a[1] !== (32'hA500_0000 + k)) begin
        nerrors++;
        $display("FAIL b2b_inst[%0d]: got %h, required %h", k, inst_a[1], 32'hA500_0000 + k);
      end
      if (k < 2) issue(1, (k + 1) * 4);
      else req_a[1] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_flush_wait();
    int cyc;
    int pulses;
    req_a[3]  = 1'b1;
    addr_a[3] = 32'h24;
    @(negedge clk);
    flush_a[3] = 1'b1;
    pulses = 0;
    @(negedge clk);
    req_a[3]   = 1'b0;
    flush_a[3] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ok_a[3] === 1'b1) pulses++;
    end
    nchecks++;
    if (pulses != 0) begin
      nerrors++;
      $display("FAIL flush_wait_no_resp: got %0d pulses, required 0", pulses);
    end
    issue(3, 32'h20);
    wait_ok(3, 8, cyc);
    req_a[3] = 1'b0;
    nchecks++;
    if (ok_a[3] !== 1'b1 || cyc != 3 || inst_a[3] !== 32'hA500_0008) begin
      nerrors++;
      $display("FAIL flush_wait_refetch: got ok=%b cyc=%0d inst=%h, required ok=1 cyc=3 inst=a5000008",
               ok_a[3], cyc, inst_a[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_resp();
    int cyc;
    req_a[2]  = 1'b1;
    addr_a[2] = 32'h14;
    @(negedge clk);
    @(negedge clk);
    flush_a[2] = 1'b1;
    #1;
    nchecks++;
    if (ok_a[2] !== 1'b0 || mis_a[2] !== 1'b0) begin
      nerrors++;
      $display("FAIL flush_resp_gate: got ok=%b mis=%b, required 0/0", ok_a[2], mis_a[2]);
    end
    @(negedge clk);
    flush_a[2] = 1'b0;
    req_a[2]   = 1'b0;
    nchecks++;
    if (ok_a[2] !== 1'b0) begin
      nerrors++;
      $display("FAIL flush_resp_after: got ok=%b, required 0", ok_a[2]);
    end
    issue(2, 32'h18);
    wait_ok(2, 8, cyc);
    req_a[2] = 1'b0;
    nchecks++;
    if (ok_a[2] !== 1'b1 || cyc != 2 || inst_a[2] !== 32'hA500_0006) begin
      nerrors++;
      $display("FAIL flush_resp_idle: got ok=%b cyc=%0d inst=%h, required ok=1 cyc=2 inst=a5000006",
               ok_a[2], cyc, inst_a[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign();
    int cyc;
    issue(2, 32'h6);
    wait_ok(2, 8, cyc);
    req_a[2] = 1'b0;
    nchecks++;
    if (ok_a[2] !== 1'b1 || cyc != 2) begin
      nerrors++;
      $display("FAIL misalign_latency: got ok=%b after %0d cycles, required ok=1 after 2", ok_a[2], cyc);
    end
    nchecks++;
`ifdef INST_ALIGN_CHECK_EN
    if (inst_a[2] !== 32'h0000_0000 || mis_a[2] !== 1'b1) begin
      nerrors++;
      $display("FAIL misalign_resp: got inst=%h mis=%b, required 00000000/1", inst_a[2], mis_a[2]);
    end
`else
    if (inst_a[2] !== 32'hA500_0001 || mis_a[2] !== 1'b0) begin
      nerrors++;
      $display("FAIL misalign_resp: got inst=%h mis=%b, required a5000001/0", inst_a[2], mis_a[2]);
    end
`endif
    @(negedge clk);
  endtask

  // Load and read-capture hit index 12 on the same edge: old word comes back.
  task automatic test_load_collision();
    int cyc;
    req_a[1]  = 1'b1;
    addr_a[1] = 32'h30;
    exp_q.push_back(expect_for(32'h30));
    load_en   = 1'b1;
    load_addr = 10'd12;
    load_data = 32'h1234_5678;
    @(negedge clk);
    load_en    = 1'b0;
    model[12]  = 32'h1234_5678;
    req_a[1]   = 1'b0;
    nchecks++;
    if (ok_a[1] !== 1'b1 || inst_a[1] !== 32'hA500_000C) begin
      nerrors++;
      $display("FAIL collision_old: got ok=%b inst=%h, required ok=1 inst=a500000c", ok_a[1], inst_a[1]);
    end
    @(negedge clk);
    issue(1, 32'h30);
    wait_ok(1, 6, cyc);
    req_a[1] = 1'b0;
    nchecks++;
    if (ok_a[1] !== 1'b1 || inst_a[1] !== 32'h1234_5678) begin
      nerrors++;
      $display("FAIL collision_new: got ok=%b inst=%h, required ok=1 inst=12345678", ok_a[1], inst_a[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    req_a[3]  = 1'b1;
    addr_a[3] = 32'h28;
    @(negedge clk);
    reset_n  = 1'b0;
    req_a[3] = 1'b0;
    #1;
    nchecks++;
    if (ok_a[3] !== 1'b0 || inst_a[3] !== 32'h0 || mis_a[3] !== 1'b0) begin
      nerrors++;
      $display("FAIL reset_mid_outputs: got ok=%b inst=%h mis=%b, required 0/00000000/0",
               ok_a[3], inst_a[3], mis_a[3]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    repeat (6) begin
      @(negedge clk);
      if (ok_a[3] === 1'b1) pulses++;
    end
    nchecks++;
    if (pulses != 0) begin
      nerrors++;
      $display("FAIL reset_mid_no_resp: got %0d pulses, required 0", pulses);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    for (int d = 1; d <= 3; d++) begin
      req_a[d]   = 1'b0;
      addr_a[d]  = '0;
      flush_a[d] = 1'b0;
    end

    test_reset();
    for (int i = 0; i < 16; i++) begin
      load_word(i, 32'hA500_0000 + i);
    end
    test_single_fetch();
    test_back_to_back();
    test_flush_wait();
    test_flush_resp();
    test_misalign();
    test_load_collision();
    test_reset_mid();

    repeat (2) @(negedge clk);
    nchecks++;
    if (exp_q.size() != 0) begin
      nerrors++;
      $display("FAIL sb_drain: got %0d pending responses, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
